timing_check_mon: RTL
=====================

TIMING_CHECK_MON -- requirements
Module: timing_check_mon

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of monitored data channels.
REQ-002 SHALL have parameter LIM_W, default 8: width of the limit and interval counters.
REQ-003 SHALL have parameter CNT_W, default 8: width of the per-channel violation counters.
REQ-004 SHALL have parameter DATA_EDGE, default EDGE_RISE, with values EDGE_RISE, EDGE_FALL and EDGE_BOTH: data event polarity.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port ref_i, input, 1 bit: reference signal; its rising edge is the reference event.
REQ-008 SHALL have port data_i, input, NUM_CH bits: monitored data signals.
REQ-009 SHALL have port setup_lim, input, LIM_W bits: setup limit in cycles; 0 disables the setup check.
REQ-010 SHALL have port hold_lim, input, LIM_W bits: hold limit in cycles; 0 disables the hold check.
REQ-011 SHALL have port en, input, 1 bit: enables violation reporting.
REQ-012 SHALL have port clr, input, 1 bit: clears the counters and notifiers.
REQ-013 SHALL have port rd_sel, input, clog2(NUM_CH) bits: counter readout select.
REQ-014 SHALL have port viol_setup, output, NUM_CH bits: one-cycle setup violation pulse.
REQ-015 SHALL have port viol_hold, output, NUM_CH bits: one-cycle hold violation pulse.
REQ-016 SHALL have port notifier, output, NUM_CH bits: sticky flag, set by any violation on the channel.
REQ-017 SHALL have port rd_cnt, output, CNT_W bits: violation count of channel rd_sel, combinational mux.

Function
REQ-018 SHALL register ref_i and data_i once; an event is detected in cycle E when the registered value differs from its previous value with the configured polarity.
REQ-019 SHALL define the setup interval as E_ref − E_data in cycles; a setup violation occurs at a reference event when this interval is less than setup_lim.
REQ-020 SHALL hold the per-channel since-data counter saturated at all-ones until the first data event, so no setup violation occurs without a prior data event.
REQ-021 SHALL open a per-channel hold window (state HOLD_WIN) at each reference event; the idle state is IDLE.
REQ-022 SHALL flag a hold violation when a data event occurs with 0 < E_data − E_ref < hold_lim; the window returns to IDLE when the interval reaches hold_lim.
REQ-023 SHALL restart the hold window from zero when a new reference event occurs while in HOLD_WIN.
REQ-024 SHALL treat a reference event and a data event in the same cycle as interval 0 on both sides: a setup violation if setup_lim > 0, never a hold violation.
REQ-025 SHALL drive viol_setup and viol_hold high in cycle E+1 for exactly one cycle.
REQ-026 SHALL, in the same cycle as the pulse, set the channel notifier and increment its counter, saturating at 2^CNT_W − 1.
REQ-027 SHALL continue edge and interval tracking while en=0, but produce no pulses, notifier updates or count updates.
REQ-028 SHALL make clr zero all counters and notifiers on the next edge; if clr and a violation coincide, clr wins.
REQ-029 SHALL sample the limits every cycle; a limit change applies to the next comparison.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, set viol_setup=0, viol_hold=0, notifier=0 and all counters to 0.
REQ-031 SHALL, on reset, return all windows to IDLE, saturate the since-data counters, and load the edge history registers with the current inputs.
REQ-032 SHALL abandon any hold window or pending interval when reset is asserted mid-operation; no event is detected in the first cycle after release.

Structure
REQ-033 SHALL place the edge-mode enum and the default width constants in the shared package timing_mon_pkg.
REQ-034 SHALL implement one sub-module, tchk_channel (edge detect, interval counters, FSM, counter), instantiated NUM_CH times by generate; the top level holds the ref edge detect and the readout mux.

Verification
REQ-035 SHALL cover (NUM_CH=4, setup_lim=3, hold_lim=2): data_i[0] rises at cycle 10, ref at 12 -> viol_setup[0] high at 13 only, notifier[0]=1, rd_cnt(sel 0)=1.
REQ-036 SHALL cover: data_i[0] at 10, ref at 13 -> no violation.
REQ-037 SHALL cover: ref at 20 and data_i[1] at 21 -> viol_hold[1] at 22; data_i[2] at 22 -> no violation.
REQ-038 SHALL cover: ref and data_i[2] in the same cycle 30 -> viol_setup[2] at 31 and viol_hold[2]=0; with setup_lim=0 -> nothing.
REQ-039 SHALL cover: 300 forced setup violations on channel 3 -> rd_cnt=255; clr -> 0 and notifier[3]=0.
REQ-040 SHALL cover: rst during HOLD_WIN followed by a data edge -> no violation; ref right after reset release -> no setup violation.

Source files
------------

// File: rtl/timing_mon_pkg.sv
// Shared types and defaults for the setup/hold timing-check monitor.
package timing_mon_pkg;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  typedef enum logic {
    IDLE     = 1'b0,
    HOLD_WIN = 1'b1
  } win_state_e;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_LIM_W  = 8;
  localparam int DEF_CNT_W  = 8;

  // Event on a registered signal given its previous value and the edge polarity.
  function automatic logic edge_detect(input logic prev, input logic cur, input edge_mode_e mode);
    case (mode)
      EDGE_RISE: return cur & ~prev;
      EDGE_FALL: return ~cur & prev;
      default:   return cur ^ prev;
    endcase
  endfunction

endpackage

// File: rtl/tchk_channel.sv
// One monitored channel: data edge detect, setup/hold interval tracking,
// hold-window FSM, violation pulses, sticky notifier and saturating counter.
module tchk_channel
  import timing_mon_pkg::*;
#(
  parameter int         LIM_W     = DEF_LIM_W,
  parameter int         CNT_W     = DEF_CNT_W,
  parameter edge_mode_e DATA_EDGE = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_i,
  input  logic             ref_evt,
  input  logic [LIM_W-1:0] setup_lim,
  input  logic [LIM_W-1:0] hold_lim,
  input  logic             en,
  input  logic             clr,
  output logic             viol_setup,
  output logic             viol_hold,
  output logic             notifier,
  output logic [CNT_W-1:0] cnt
);

  logic             data_q;
  logic             data_prev;
  logic             data_evt;
  logic [LIM_W-1:0] since_cnt;
  logic [LIM_W-1:0] hold_cnt;
  logic [LIM_W-1:0] setup_ivl;
  logic             setup_hit;
  logic             hold_hit;
  win_state_e       state;

  // Data history; reset loads the live input so no event appears right after release.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= data_i;
      data_prev <= data_i;
    end else begin
      data_q    <= data_i;
      data_prev <= data_q;
    end
  end

  // Event detect and the setup/hold comparisons for this cycle.
  always_comb begin
    data_evt  = edge_detect(data_prev, data_q, DATA_EDGE);
    setup_ivl = data_evt ? '0 : since_cnt;
    setup_hit = ref_evt && (setup_ivl < setup_lim);
    hold_hit  = !ref_evt && (state == HOLD_WIN) && data_evt && (hold_cnt < hold_lim);
  end

  // Cycles since the last data event, parked at all-ones until one has been seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      since_cnt <= '1;
    end else if (data_evt) begin
      since_cnt <= LIM_W'(1);
    end else if (since_cnt != '1) begin
      since_cnt <= since_cnt + 1'b1;
    end
  end

  // Hold window FSM; hold_cnt holds the cycles elapsed since the reference event.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else if (ref_evt) begin
      state    <= HOLD_WIN;
      hold_cnt <= LIM_W'(1);
    end else if (state == HOLD_WIN) begin
      if (hold_cnt >= hold_lim) begin
        state <= IDLE;
      end else if (hold_cnt != '1) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  // Registered pulses, sticky notifier and saturating count; clr overrides a coincident hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_setup <= 1'b0;
      viol_hold  <= 1'b0;
      notifier   <= 1'b0;
      cnt        <= '0;
    end else begin
      viol_setup <= en & setup_hit;
      viol_hold  <= en & hold_hit;
      if (clr) begin
        notifier <= 1'b0;
        cnt      <= '0;
      end else if (en && (setup_hit || hold_hit)) begin
        notifier <= 1'b1;
        if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/timing_check_mon.sv
// Setup/hold timing-check monitor: shared reference edge detect, one
// tchk_channel per data bit, and a combinational counter readout mux.
module timing_check_mon
  import timing_mon_pkg::*;
#(
  parameter int         NUM_CH    = DEF_NUM_CH,
  parameter int         LIM_W     = DEF_LIM_W,
  parameter int         CNT_W     = DEF_CNT_W,
  parameter edge_mode_e DATA_EDGE = EDGE_RISE,
  localparam int        SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ref_i,
  input  logic [NUM_CH-1:0] data_i,
  input  logic [LIM_W-1:0]  setup_lim,
  input  logic [LIM_W-1:0]  hold_lim,
  input  logic              en,
  input  logic              clr,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [NUM_CH-1:0] viol_setup,
  output logic [NUM_CH-1:0] viol_hold,
  output logic [NUM_CH-1:0] notifier,
  output logic [CNT_W-1:0]  rd_cnt
);

  logic             ref_q;
  logic             ref_prev;
  logic             ref_evt;
  logic [CNT_W-1:0] cnt_arr [NUM_CH];

  // Reference history; reset loads the live input so release does not fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q    <= ref_i;
      ref_prev <= ref_i;
    end else begin
      ref_q    <= ref_i;
      ref_prev <= ref_q;
    end
  end

  assign ref_evt = ref_q & ~ref_prev;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tchk_channel #(
      .LIM_W    (LIM_W),
      .CNT_W    (CNT_W),
      .DATA_EDGE(DATA_EDGE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .data_i    (data_i[g]),
      .ref_evt   (ref_evt),
      .setup_lim (setup_lim),
      .hold_lim  (hold_lim),
      .en        (en),
      .clr       (clr),
      .viol_setup(viol_setup[g]),
      .viol_hold (viol_hold[g]),
      .notifier  (notifier[g]),
      .cnt       (cnt_arr[g])
    );
  end

  // Readout mux; a select beyond the last channel reads zero.
  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_cnt = cnt_arr[i];
      end
    end
  end

endmodule
